// File: rtl/vecmac_job_sched_if.sv
// rtl/vecmac_job_sched_if.sv - command, operand-beat, accumulator and result bundle of the job sequencer
interface vecmac_job_sched_if #(
  parameter int ADDR_W = 16,
  parameter int W_ACC  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_lanes;
  logic [ADDR_W-1:0] cmd_base;

  logic              beat_valid;
  logic              beat_ready;
  logic [ADDR_W-1:0] beat_addr;
  logic [15:0]       beat_mask;
  logic              beat_last;

  logic              acc_start;
  logic [4:0]        acc_lanes;
  logic              acc_result_valid;
  logic [W_ACC-1:0]  acc_final_sum;

  logic              res_valid;
  logic              res_ready;
  logic [W_ACC-1:0]  res_sum;
  logic              res_err;

  modport master (
    output cmd_valid, cmd_lanes, cmd_base, beat_ready,
    output acc_result_valid, acc_final_sum, res_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_mask, beat_last,
    input  acc_start, acc_lanes, res_valid, res_sum, res_err
  );

  modport slave (
    input  cmd_valid, cmd_lanes, cmd_base, beat_ready,
    input  acc_result_valid, acc_final_sum, res_ready,
    output cmd_ready, beat_valid, beat_addr, beat_mask, beat_last,
    output acc_start, acc_lanes, res_valid, res_sum, res_err
  );
endinterface

// File: rtl/vecmac_job_sched.sv
// rtl/vecmac_job_sched.sv - sequences one dot-product job: operand beats, accumulator drain, result handshake
module vecmac_job_sched #(
  parameter int ELEMS   = 1000,
  parameter int W_ACC   = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vecmac_job_sched_if.slave     bus,
  output logic                  busy
);

  localparam int IDX_W = $clog2(ELEMS + 1);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state, state_nx;

  logic [4:0]        lanes_q;
  logic [2:0]        shift_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  nbeats;
  logic [4:0]        rem_q;
  logic [CNT_W-1:0]  drain_cnt;
  logic              start_q;
  logic [W_ACC-1:0]  sum_q;
  logic              err_q;

  logic              cmd_fire;
  logic              lanes_legal;
  logic [2:0]        cmd_shift;
  logic [31:0]       nb_full;
  logic [31:0]       rem_full;
  logic              beat_fire;
  logic              last_beat;
  logic              timeout_hit;
  logic [31:0]       beat_off;

  function automatic logic [15:0] lane_mask(input logic [4:0] n);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) begin
      m[i] = (5'(i) < n);
    end
    return m;
  endfunction

  // Lane counts are powers of two, so the beat count and offset reduce to shifts.
  always_comb begin
    lanes_legal = 1'b1;
    cmd_shift   = 3'd0;
    case (bus.cmd_lanes)
      5'd1:    cmd_shift = 3'd0;
      5'd2:    cmd_shift = 3'd1;
      5'd4:    cmd_shift = 3'd2;
      5'd8:    cmd_shift = 3'd3;
      5'd16:   cmd_shift = 3'd4;
      default: lanes_legal = 1'b0;
    endcase
    nb_full  = (32'(ELEMS) + 32'(bus.cmd_lanes) - 32'd1) >> cmd_shift;
    rem_full = 32'(ELEMS) - ((nb_full - 32'd1) << cmd_shift);
  end

  assign cmd_fire    = bus.cmd_valid && (state == S_IDLE);
  assign beat_fire   = bus.beat_ready && (state == S_ISSUE);
  assign last_beat   = (beat_idx == nbeats - 1'b1);
  assign timeout_hit = (drain_cnt == CNT_W'(TIMEOUT - 1));
  assign beat_off    = 32'(beat_idx) << shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_fire) state_nx = lanes_legal ? S_ISSUE : S_RESP;
      S_ISSUE: if (beat_fire && last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (bus.acc_result_valid || timeout_hit) state_nx = S_RESP;
      S_RESP:  if (bus.res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q   <= 5'd1;
      shift_q   <= 3'd0;
      base_q    <= '0;
      beat_idx  <= '0;
      nbeats    <= '0;
      rem_q     <= 5'd0;
      drain_cnt <= '0;
      start_q   <= 1'b0;
      sum_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            base_q    <= bus.cmd_base;
            beat_idx  <= '0;
            drain_cnt <= '0;
            sum_q     <= '0;
            err_q     <= !lanes_legal;
            // acc_lanes only follows legal commands so the accumulator never sees a bad count.
            if (lanes_legal) begin
              lanes_q <= bus.cmd_lanes;
              shift_q <= cmd_shift;
              nbeats  <= IDX_W'(nb_full);
              rem_q   <= 5'(rem_full);
              start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (beat_fire) beat_idx <= beat_idx + 1'b1;
        end
        S_DRAIN: begin
          if (bus.acc_result_valid) begin
            sum_q <= bus.acc_final_sum;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            sum_q <= '0;
            err_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready  = (state == S_IDLE);
    bus.beat_valid = (state == S_ISSUE);
    bus.beat_last  = (state == S_ISSUE) && last_beat;
    bus.beat_addr  = '0;
    bus.beat_mask  = '0;
    if (state == S_ISSUE) begin
      bus.beat_addr = base_q + beat_off[ADDR_W-1:0];
      bus.beat_mask = lane_mask(last_beat ? rem_q : lanes_q);
    end
    bus.acc_start  = start_q;
    bus.acc_lanes  = lanes_q;
    bus.res_valid  = (state == S_RESP);
    bus.res_sum    = sum_q;
    bus.res_err    = err_q;
    busy           = (state != S_IDLE);
  end

endmodule
